sdram_arb: RTL
==============

SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 SHALL provide parameter RFSH_PERIOD, default 780, clk cycles between refresh-request toggles.
REQ-002 SHALL provide port clk  input  1  system clock, ~96-100 MHz; all logic on rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port req  input  3  per-port request level, bit n = port n.
REQ-005 SHALL provide port we  input  3  per-port write flag, 1=write, 0=read.
REQ-006 SHALL provide port addr  input  78  per-port word address [26:1], port n at bits [26n+25:26n].
REQ-007 SHALL provide port bs  input  6  per-port byte strobes, port n at [2n+1:2n], bit1=high byte.
REQ-008 SHALL provide port din  input  48  per-port write data, port n at [16n+15:16n].
REQ-009 SHALL provide port ack  output  3  one-cycle completion pulse per port.
REQ-010 SHALL provide port dout  output  16  read data shared by all ports, valid in the ack cycle.
REQ-011 SHALL provide ports sd_sel/sd_rd/sd_wr  output  1 each  request strobes to the SDRAM controller.
REQ-012 SHALL provide ports sd_addr  output  26, sd_bs  output  2, sd_din  output  16  granted access parameters.
REQ-013 SHALL provide ports sd_ready  input  1, sd_dout  input  16  controller status and read data.
REQ-014 SHALL provide port sd_refresh  output  1  refresh request toggle; each edge requests one auto-refresh.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_LOW, WAIT_HIGH, DONE.
REQ-016 IDLE: if any req bit set and sd_ready=1, SHALL grant one port, latch its we/addr/bs/din into sd_* registers, and enter WAIT_LOW next cycle; if sd_ready=0, no grant.
REQ-017 Arbitration SHALL be round-robin: search order starts at (last_grant+1) mod 3; last_grant updates on each grant.
REQ-018 WAIT_LOW: SHALL hold sd_sel=1 and sd_wr=we / sd_rd=~we until sd_ready=0 is sampled, then deassert sd_sel/sd_rd/sd_wr and enter WAIT_HIGH.
REQ-019 WAIT_LOW SHALL wait unbounded (controller may be servicing refresh with sd_ready=1); sd_addr/sd_din/sd_bs SHALL remain stable throughout.
REQ-020 WAIT_HIGH: on sampled sd_ready=1, SHALL register dout<=sd_dout, pulse ack[grant] in the following cycle, and enter DONE.
REQ-021 DONE: SHALL return to IDLE after one cycle, so the requester has one cycle after ack to drop req; a req still high in IDLE is a new access.
REQ-022 Minimum latency: req seen in IDLE at edge N -> sd_sel high from N+1; ack never earlier than two cycles after sd_ready falls.
REQ-023 ack SHALL be one-hot or zero; dout SHALL hold its value until the next completed access.
REQ-024 On a write, dout SHALL be updated identically (ignored by requester); ack timing SHALL be identical to a read.
REQ-025 Refresh counter SHALL count 0..RFSH_PERIOD-1 free-running and toggle sd_refresh on each wrap, independent of FSM state.
REQ-026 Simultaneous req on all ports from reset SHALL be served in order 0,1,2; port deasserting req before grant SHALL not be served.

Reset
REQ-027 On reset: state=IDLE, last_grant=2, ack=0, dout=0, sd_sel/sd_rd/sd_wr=0, sd_addr/sd_bs/sd_din=0, sd_refresh=0, refresh counter=0.
REQ-028 Reset asserted mid-access SHALL abort immediately with no ack; the aborted port is re-arbitrated normally after release.

Verification
REQ-029 Single read: port1 req, we=0, addr=0x0123456; model drops sd_ready 2 cycles after sd_sel, raises it 6 later with sd_dout=0xBEEF -> sd_addr=0x0123456, sd_rd held until ready low, ack=3'b010 once, dout=0xBEEF.
REQ-030 Round-robin: all three req held high from reset -> ack sequence 001,010,100,001; no port served twice while another waits.
REQ-031 Write: port2 we=1, bs=2'b01, din=0x00A5 -> sd_wr=1, sd_bs=01, sd_din=0x00A5 stable until sd_ready low; ack=3'b100.
REQ-032 Refresh: RFSH_PERIOD=8 -> sd_refresh toggles every 8 cycles, including during WAIT_LOW with sd_ready held high 20 cycles; access completes afterwards.
REQ-033 Blocking: sd_ready=0 in IDLE with req=3'b001 -> no sd_sel until sd_ready=1.
REQ-034 Mid-access reset: assert reset in WAIT_HIGH -> all outputs reset values next cycle, no ack pulse.

Source files
------------

// File: rtl/sdram_arb.sv
// rtl/sdram_arb.sv - three-port round-robin arbiter in front of an SDRAM controller
module sdram_arb #(
    parameter int RFSH_PERIOD = 780
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  we,
    input  logic [77:0] addr,
    input  logic [5:0]  bs,
    input  logic [47:0] din,
    output logic [2:0]  ack,
    output logic [15:0] dout,
    output logic        sd_sel,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic [25:0] sd_addr,
    output logic [1:0]  sd_bs,
    output logic [15:0] sd_din,
    input  logic        sd_ready,
    input  logic [15:0] sd_dout,
    output logic        sd_refresh
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_LOW  = 2'd1;
    localparam logic [1:0] S_WAIT_HIGH = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    localparam int              CW      = (RFSH_PERIOD > 1) ? $clog2(RFSH_PERIOD) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(RFSH_PERIOD - 1);

    logic [1:0]    r_state;
    logic [1:0]    r_last;
    logic [1:0]    r_grant;
    logic [2:0]    r_ack;
    logic [15:0]   r_dout;
    logic          r_sel;
    logic          r_rd;
    logic          r_wr;
    logic [25:0]   r_addr;
    logic [1:0]    r_bs;
    logic [15:0]   r_din;
    logic [CW-1:0] r_rfsh_cnt;
    logic          r_refresh;

    logic [1:0]    w_pick;
    logic          w_any;
    logic          w_we;
    logic [25:0]   w_addr;
    logic [1:0]    w_bs;
    logic [15:0]   w_din;

    assign w_any = |req;

    // Round-robin choice: start looking at the port after the last one granted.
    always_comb begin
        w_pick = 2'd0;
        case (r_last)
            2'd0:    w_pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    w_pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: w_pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    // Select the access parameters of the port that would be granted.
    always_comb begin
        w_we   = we[0];
        w_addr = addr[25:0];
        w_bs   = bs[1:0];
        w_din  = din[15:0];
        case (w_pick)
            2'd1: begin
                w_we   = we[1];
                w_addr = addr[51:26];
                w_bs   = bs[3:2];
                w_din  = din[31:16];
            end
            2'd2: begin
                w_we   = we[2];
                w_addr = addr[77:52];
                w_bs   = bs[5:4];
                w_din  = din[47:32];
            end
            default: ;
        endcase
    end

    // Access handshake: grant, hold strobes until the controller goes busy,
    // wait for it to finish, then ack and give the requester a cycle to drop req.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= 2'd2;
            r_grant <= 2'd0;
            r_ack   <= 3'b000;
            r_dout  <= 16'h0000;
            r_sel   <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= 26'd0;
            r_bs    <= 2'b00;
            r_din   <= 16'h0000;
        end else begin
            r_ack <= 3'b000;
            case (r_state)
                S_IDLE: begin
                    if (w_any && sd_ready) begin
                        r_grant <= w_pick;
                        r_last  <= w_pick;
                        r_sel   <= 1'b1;
                        r_wr    <= w_we;
                        r_rd    <= ~w_we;
                        r_addr  <= w_addr;
                        r_bs    <= w_bs;
                        r_din   <= w_din;
                        r_state <= S_WAIT_LOW;
                    end
                end
                S_WAIT_LOW: begin
                    // sd_ready may stay high for a long time while a refresh runs.
                    if (!sd_ready) begin
                        r_sel   <= 1'b0;
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_state <= S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (sd_ready) begin
                        r_dout  <= sd_dout;
                        r_ack   <= 3'b001 << r_grant;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Free-running refresh timer; each wrap flips the refresh request line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rfsh_cnt <= '0;
            r_refresh  <= 1'b0;
        end else if (r_rfsh_cnt == CNT_MAX) begin
            r_rfsh_cnt <= '0;
            r_refresh  <= ~r_refresh;
        end else begin
            r_rfsh_cnt <= r_rfsh_cnt + 1'b1;
        end
    end

    assign ack        = r_ack;
    assign dout       = r_dout;
    assign sd_sel     = r_sel;
    assign sd_rd      = r_rd;
    assign sd_wr      = r_wr;
    assign sd_addr    = r_addr;
    assign sd_bs      = r_bs;
    assign sd_din     = r_din;
    assign sd_refresh = r_refresh;

endmodule
